// File: rtl/regfile_write_arbiter_if.sv
// Bundle between two writeback requesters, the register file write port and decode's hazard queries.
// Handshake: an x transfer happens on a rising clk edge where x_valid && x_ready; addr/data are taken at that edge.
interface regfile_write_arbiter_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic              a_valid;
   logic              a_ready;
   logic [ADDR_W-1:0] a_addr;
   logic [DATA_W-1:0] a_data;
   logic              b_valid;
   logic              b_ready;
   logic [ADDR_W-1:0] b_addr;
   logic [DATA_W-1:0] b_data;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic [ADDR_W-1:0] q_addr_l;
   logic [ADDR_W-1:0] q_addr_r;
   logic              busy_l;
   logic              busy_r;

   modport master (
      output a_valid, a_addr, a_data, b_valid, b_addr, b_data, q_addr_l, q_addr_r,
      input  a_ready, b_ready, wr_en, wr_addr, wr_data, busy_l, busy_r
   );

   modport slave (
      input  a_valid, a_addr, a_data, b_valid, b_addr, b_data, q_addr_l, q_addr_r,
      output a_ready, b_ready, wr_en, wr_addr, wr_data, busy_l, busy_r
   );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Two writeback FIFOs (A = ALU, B = load) sharing one register file write port through a
// round-robin arbiter with a registered output stage and RAW busy lookups.
module regfile_write_arbiter #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 2
) (
   input logic                    clk,
   input logic                    rst,
   regfile_write_arbiter_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   // Index 0 is source A, index 1 is source B throughout.
   logic [ADDR_W-1:0] fifo_addr_q [2][DEPTH];
   logic [DATA_W-1:0] fifo_data_q [2][DEPTH];
   logic [DEPTH-1:0]  fifo_vld_q  [2];
   logic [PTR_W-1:0]  wp_q        [2];
   logic [PTR_W-1:0]  rp_q        [2];
   logic [CNT_W-1:0]  cnt_q       [2];
   logic              last_grant_q;
   logic              wr_en_q;
   logic [ADDR_W-1:0] wr_addr_q;
   logic [DATA_W-1:0] wr_data_q;

   logic [ADDR_W-1:0] in_addr [2];
   logic [DATA_W-1:0] in_data [2];
   logic [1:0]        in_valid;
   logic [1:0]        ready;
   logic [1:0]        push;
   logic [1:0]        nonempty;
   logic [1:0]        pop;
   logic              wr_en_d;
   logic [ADDR_W-1:0] wr_addr_d;
   logic [DATA_W-1:0] wr_data_d;
   logic              hit_l;
   logic              hit_r;

   assign in_valid   = {bus.b_valid, bus.a_valid};
   assign in_addr[0] = bus.a_addr;
   assign in_addr[1] = bus.b_addr;
   assign in_data[0] = bus.a_data;
   assign in_data[1] = bus.b_data;

   // Writes to r0 are acknowledged but never stored.
   always_comb begin
      ready    = '0;
      push     = '0;
      nonempty = '0;
      for (int s = 0; s < 2; s++) begin
         ready[s]    = !rst && (cnt_q[s] < CNT_W'(DEPTH));
         push[s]     = in_valid[s] && ready[s] && (in_addr[s] != '0);
         nonempty[s] = (cnt_q[s] != '0);
      end
   end

   always_comb begin
      pop = 2'b00;
      if (nonempty[0] && (!nonempty[1] || last_grant_q)) begin
         pop[0] = 1'b1;
      end else if (nonempty[1]) begin
         pop[1] = 1'b1;
      end
   end

   always_comb begin
      wr_en_d   = |pop;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      if (|pop) begin
         wr_addr_d = fifo_addr_q[pop[1]][rp_q[pop[1]]];
         wr_data_d = fifo_data_q[pop[1]][rp_q[pop[1]]];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < 2; s++) begin
            fifo_vld_q[s] <= '0;
            wp_q[s]       <= '0;
            rp_q[s]       <= '0;
            cnt_q[s]      <= '0;
         end
         last_grant_q <= 1'b1;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
      end else begin
         for (int s = 0; s < 2; s++) begin
            if (push[s]) begin
               fifo_addr_q[s][wp_q[s]] <= in_addr[s];
               fifo_data_q[s][wp_q[s]] <= in_data[s];
               fifo_vld_q[s][wp_q[s]]  <= 1'b1;
               wp_q[s]                 <= wp_q[s] + PTR_W'(1);
            end
            if (pop[s]) begin
               fifo_vld_q[s][rp_q[s]] <= 1'b0;
               rp_q[s]                <= rp_q[s] + PTR_W'(1);
            end
            if (push[s] && !pop[s]) begin
               cnt_q[s] <= cnt_q[s] + CNT_W'(1);
            end else if (!push[s] && pop[s]) begin
               cnt_q[s] <= cnt_q[s] - CNT_W'(1);
            end
         end
         if (|pop) begin
            last_grant_q <= pop[1];
         end
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
      end
   end

   // Busy looks only at registered state; this cycle's incoming transfers are not visible yet.
   always_comb begin
      hit_l = wr_en_q && (wr_addr_q == bus.q_addr_l);
      hit_r = wr_en_q && (wr_addr_q == bus.q_addr_r);
      for (int s = 0; s < 2; s++) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (fifo_vld_q[s][i] && (fifo_addr_q[s][i] == bus.q_addr_l)) hit_l = 1'b1;
            if (fifo_vld_q[s][i] && (fifo_addr_q[s][i] == bus.q_addr_r)) hit_r = 1'b1;
         end
      end
   end

   assign bus.a_ready = ready[0];
   assign bus.b_ready = ready[1];
   assign bus.wr_en   = wr_en_q;
   assign bus.wr_addr = wr_addr_q;
   assign bus.wr_data = wr_data_q;
   assign bus.busy_l  = !rst && (bus.q_addr_l != '0) && hit_l;
   assign bus.busy_r  = !rst && (bus.q_addr_r != '0) && hit_r;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed reset/latency/contention/backpressure/r0/hazard
// sequences plus random single-source traffic, with every register file write checked against exp_q.
module tb_regfile_write_arbiter;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int DEPTH  = 2;
   localparam int EW     = ADDR_W + DATA_W;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   regfile_write_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   regfile_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [EW-1:0]     exp_q[$];
   logic [EW-1:0]     mon_e;
   logic [ADDR_W-1:0] cont_order [4] = '{5'd1, 5'd7, 5'd2, 5'd8};
   int                n_checks = 0;
   int                n_fail   = 0;
   int                ia;
   int                ib;
   logic              acc_a;
   logic              acc_b;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // ---------------- clock/reset and driver tasks ----------------
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.a_valid = 1'b0;
      bus.a_addr  = '0;
      bus.a_data  = '0;
      bus.b_valid = 1'b0;
      bus.b_addr  = '0;
      bus.b_data  = '0;
   endtask

   task automatic do_reset(input int cycles);
      rst = 1'b1;
      idle_inputs();
      repeat (cycles) next_cycle();
      rst = 1'b0;
   endtask

   task automatic drive_a(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
      bus.a_valid = 1'b1;
      bus.a_addr  = addr;
      bus.a_data  = data;
   endtask

   task automatic drive_b(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
      bus.b_valid = 1'b1;
      bus.b_addr  = addr;
      bus.b_data  = data;
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) next_cycle();
      repeat (2) next_cycle();
      check(tag, exp_q.size(), 0);
   endtask

   // ---------------- scoreboard: every write must match the head of exp_q ----------------
   always @(negedge clk) begin
      if (bus.wr_en === 1'b1) begin
         check("wr_addr_nonzero", bus.wr_addr == '0, 1'b0);
         if (exp_q.size() == 0) begin
            check("spurious_wr", bus.wr_en, 1'b0);
         end else begin
            mon_e = exp_q.pop_front();
            check("wr_addr", bus.wr_addr, mon_e[EW-1:DATA_W]);
            check("wr_data", bus.wr_data, mon_e[DATA_W-1:0]);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // ---- reset values ----
      bus.q_addr_l = 5'd3;
      bus.q_addr_r = 5'd4;
      do_reset(2);
      rst = 1'b1;
      @(negedge clk);
      check("rst_a_ready", bus.a_ready, 1'b0);
      check("rst_b_ready", bus.b_ready, 1'b0);
      check("rst_wr_en", bus.wr_en, 1'b0);
      check("rst_busy_l", bus.busy_l, 1'b0);
      next_cycle();
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_a_ready", bus.a_ready, 1'b1);
      check("post_rst_b_ready", bus.b_ready, 1'b1);
      check("post_rst_wr_addr", bus.wr_addr, '0);
      check("post_rst_wr_data", bus.wr_data, '0);
      next_cycle();

      // ---- reset mid-operation: accepted r3 and offered r4 never written ----
      drive_a(5'd3, 32'h11);
      @(negedge clk);
      check("mid_acc3_ready", bus.a_ready, 1'b1);
      next_cycle();
      drive_a(5'd4, 32'h22);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_a_ready", bus.a_ready, 1'b0);
      check("mid_rst_busy_l", bus.busy_l, 1'b0);
      next_cycle();
      rst = 1'b0;
      idle_inputs();
      @(negedge clk);
      check("mid_post_a_ready", bus.a_ready, 1'b1);
      check("mid_post_busy_l", bus.busy_l, 1'b0);
      check("mid_post_busy_r", bus.busy_r, 1'b0);
      repeat (3) begin
         next_cycle();
         @(negedge clk);
         check("mid_post_wr_en", bus.wr_en, 1'b0);
      end
      next_cycle();

      // ---- single write latency ----
      drive_a(5'd5, 32'hDEADBEEF);
      exp_q.push_back({5'd5, 32'hDEADBEEF});
      @(negedge clk);
      check("lat_pre_wr_en", bus.wr_en, 1'b0);
      next_cycle();
      idle_inputs();
      @(negedge clk);
      check("lat_n_wr_en", bus.wr_en, 1'b0);
      next_cycle();
      @(negedge clk);
      check("lat_n1_wr_en", bus.wr_en, 1'b1);
      check("lat_n1_wr_addr", bus.wr_addr, 5'd5);
      check("lat_n1_wr_data", bus.wr_data, 32'hDEADBEEF);
      next_cycle();
      @(negedge clk);
      check("lat_n2_wr_en", bus.wr_en, 1'b0);
      check("lat_hold_addr", bus.wr_addr, 5'd5);
      check("lat_hold_data", bus.wr_data, 32'hDEADBEEF);
      drain("lat_drain");

      // ---- contention: A wins first tie after reset, then alternate ----
      do_reset(1);
      exp_q.push_back({5'd1, 32'hA1});
      exp_q.push_back({5'd7, 32'hB7});
      exp_q.push_back({5'd2, 32'hA2});
      exp_q.push_back({5'd8, 32'hB8});
      drive_a(5'd1, 32'hA1);
      drive_b(5'd7, 32'hB7);
      next_cycle();
      drive_a(5'd2, 32'hA2);
      drive_b(5'd8, 32'hB8);
      @(negedge clk);
      check("cont_c1_a_ready", bus.a_ready, 1'b1);
      check("cont_c1_b_ready", bus.b_ready, 1'b1);
      check("cont_c1_wr_en", bus.wr_en, 1'b0);
      next_cycle();
      idle_inputs();
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("cont_wr_en", bus.wr_en, 1'b1);
         check("cont_order", bus.wr_addr, cont_order[k]);
         next_cycle();
      end
      @(negedge clk);
      check("cont_done_wr_en", bus.wr_en, 1'b0);
      drain("cont_drain");

      // ---- backpressure: B fills while sharing the port with A ----
      do_reset(1);
      exp_q.push_back({5'd11, 32'hA0});
      exp_q.push_back({5'd21, 32'hB0});
      exp_q.push_back({5'd12, 32'hA1});
      exp_q.push_back({5'd22, 32'hB1});
      exp_q.push_back({5'd13, 32'hA2});
      exp_q.push_back({5'd23, 32'hB2});
      exp_q.push_back({5'd14, 32'hA3});
      ia = 0;
      ib = 0;
      for (int c = 0; c < 8; c++) begin
         idle_inputs();
         if (ia < 4) drive_a(ADDR_W'(11 + ia), DATA_W'(32'hA0 + ia));
         if (ib < 3) drive_b(ADDR_W'(21 + ib), DATA_W'(32'hB0 + ib));
         @(negedge clk);
         if (c == 2) begin
            check("bp_b_full", bus.b_ready, 1'b0);
            check("bp_a_ready_c2", bus.a_ready, 1'b1);
         end
         if (c == 3) begin
            check("bp_b_freed", bus.b_ready, 1'b1);
            check("bp_a_full", bus.a_ready, 1'b0);
         end
         acc_a = bus.a_valid && bus.a_ready;
         acc_b = bus.b_valid && bus.b_ready;
         next_cycle();
         if (acc_a) ia++;
         if (acc_b) ib++;
      end
      idle_inputs();
      check("bp_all_a", ia, 4);
      check("bp_all_b", ib, 3);
      drain("bp_drain");

      // ---- r0 write: handshake completes, nothing issued, never busy ----
      bus.q_addr_l = 5'd0;
      drive_b(5'd0, 32'h1234);
      @(negedge clk);
      check("zero_b_ready", bus.b_ready, 1'b1);
      next_cycle();
      idle_inputs();
      repeat (3) begin
         @(negedge clk);
         check("zero_wr_en", bus.wr_en, 1'b0);
         check("zero_busy_l", bus.busy_l, 1'b0);
         next_cycle();
      end

      // ---- hazard window ----
      bus.q_addr_l = 5'd9;
      bus.q_addr_r = 5'd10;
      drive_a(5'd9, 32'h99);
      exp_q.push_back({5'd9, 32'h99});
      @(negedge clk);
      check("hz_same_cycle_busy_l", bus.busy_l, 1'b0);
      next_cycle();
      idle_inputs();
      @(negedge clk);
      check("hz_fifo_busy_l", bus.busy_l, 1'b1);
      check("hz_fifo_busy_r", bus.busy_r, 1'b0);
      next_cycle();
      @(negedge clk);
      check("hz_out_wr_en", bus.wr_en, 1'b1);
      check("hz_out_busy_l", bus.busy_l, 1'b1);
      check("hz_out_busy_r", bus.busy_r, 1'b0);
      next_cycle();
      @(negedge clk);
      check("hz_after_busy_l", bus.busy_l, 1'b0);
      check("hz_after_busy_r", bus.busy_r, 1'b0);
      drain("hz_drain");

      // ---- random traffic, one source per cycle so issue order equals acceptance order ----
      bus.q_addr_l = 5'd0;
      bus.q_addr_r = 5'd0;
      for (int c = 0; c < 40; c++) begin
         idle_inputs();
         case ($urandom_range(0, 2))
            0: drive_a(ADDR_W'($urandom_range(0, 31)), $urandom);
            1: drive_b(ADDR_W'($urandom_range(0, 31)), $urandom);
            default: ;
         endcase
         @(negedge clk);
         if (bus.a_valid && bus.a_ready && bus.a_addr != '0) exp_q.push_back({bus.a_addr, bus.a_data});
         if (bus.b_valid && bus.b_ready && bus.b_addr != '0) exp_q.push_back({bus.b_addr, bus.b_data});
         if (bus.a_valid) check("rnd_a_ready", bus.a_ready, 1'b1);
         if (bus.b_valid) check("rnd_b_ready", bus.b_ready, 1'b1);
         next_cycle();
      end
      idle_inputs();
      drain("rnd_drain");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
